// File: rtl/servo_pwm_sched_if.sv
// Command and status bundle between the servo scheduler and its requesters / output stage.
interface servo_pwm_sched_if;
  localparam int unsigned W_W = 12;

  logic           enable;
  logic           a_wr;
  logic [W_W-1:0] a_width;
  logic           b_wr;
  logic [W_W-1:0] b_width;
  logic           pwm_out;
  logic           frame_start;
  logic [W_W-1:0] width_cur;
  logic [1:0]     active_src;
  logic           timeout;

  modport master (
    output enable, a_wr, a_width, b_wr, b_width,
    input  pwm_out, frame_start, width_cur, active_src, timeout
  );

  modport slave (
    input  enable, a_wr, a_width, b_wr, b_width,
    output pwm_out, frame_start, width_cur, active_src, timeout
  );
endinterface

// File: rtl/servo_pwm_sched.sv
// Servo PWM frame generator with two-source width arbitration applied at frame boundaries
// and a deadman fallback to the neutral (stopped) width.
module servo_pwm_sched #(
  parameter int unsigned CLK_PER_US     = 10,
  parameter int unsigned FRAME_US       = 20000,
  parameter int unsigned MIN_US         = 1000,
  parameter int unsigned MAX_US         = 2000,
  parameter int unsigned NEUTRAL_US     = 1500,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input logic              SYSCLK,
  input logic              SYSRESET,
  servo_pwm_sched_if.slave bus
);

  localparam int unsigned W_W   = 12;
  localparam int unsigned PSC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [PSC_W-1:0] psc, psc_nxt;
  logic [US_W-1:0]  us_cnt, us_nxt;
  logic [W_W-1:0]   a_pend, a_pend_nxt, b_pend, b_pend_nxt;
  logic             a_fresh, a_fresh_nxt, b_fresh, b_fresh_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;

  logic             pwm_q, pwm_nxt;
  logic             fs_q, fs_nxt;
  logic [W_W-1:0]   width_q, width_nxt;
  logic [1:0]       src_q, src_nxt;
  logic             timeout_q, timeout_nxt;

  logic             a_fresh_eff, b_fresh_eff;

  function automatic logic [W_W-1:0] clamp_w(input logic [W_W-1:0] w);
    if (w < W_W'(MIN_US)) begin
      return W_W'(MIN_US);
    end else if (w > W_W'(MAX_US)) begin
      return W_W'(MAX_US);
    end
    return w;
  endfunction

  // State register
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enable alone moves between idle and running
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.enable)  state_nxt = ST_RUN;
      ST_RUN:  if (!bus.enable) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; outputs describe the cycle being entered
  always_comb begin
    psc_nxt     = '0;
    us_nxt      = '0;
    a_pend_nxt  = bus.a_wr ? bus.a_width : a_pend;
    b_pend_nxt  = bus.b_wr ? bus.b_width : b_pend;
    a_fresh_nxt = a_fresh | bus.a_wr;
    b_fresh_nxt = b_fresh | bus.b_wr;
    a_fresh_eff = a_fresh | bus.a_wr;
    b_fresh_eff = b_fresh | bus.b_wr;
    to_cnt_nxt  = to_cnt;
    width_nxt   = width_q;
    src_nxt     = src_q;
    timeout_nxt = timeout_q;
    fs_nxt      = 1'b0;
    pwm_nxt     = 1'b0;

    if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
      if (32'(psc) == CLK_PER_US - 1) begin
        psc_nxt = '0;
        us_nxt  = (32'(us_cnt) == FRAME_US - 1) ? '0 : us_cnt + US_W'(1);
      end else begin
        psc_nxt = psc + PSC_W'(1);
        us_nxt  = us_cnt;
      end
    end

    fs_nxt = (state_nxt == ST_RUN) && (psc_nxt == '0) && (us_nxt == '0);

    // A write in the cycle just before the boundary still belongs to the ending frame
    if (fs_nxt) begin
      a_fresh_nxt = 1'b0;
      b_fresh_nxt = 1'b0;
      if (a_fresh_eff) begin
        width_nxt   = clamp_w(a_pend_nxt);
        src_nxt     = 2'd1;
        to_cnt_nxt  = '0;
        timeout_nxt = 1'b0;
      end else if (b_fresh_eff) begin
        width_nxt   = clamp_w(b_pend_nxt);
        src_nxt     = 2'd2;
        to_cnt_nxt  = '0;
        timeout_nxt = 1'b0;
      end else begin
        if (32'(to_cnt) < TIMEOUT_FRAMES) begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
        if (32'(to_cnt_nxt) == TIMEOUT_FRAMES) begin
          width_nxt   = W_W'(NEUTRAL_US);
          src_nxt     = 2'd0;
          timeout_nxt = 1'b1;
        end
      end
    end

    pwm_nxt = (state_nxt == ST_RUN) && (32'(us_nxt) < 32'(width_nxt));
  end

  // Datapath and output registers
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      psc       <= '0;
      us_cnt    <= '0;
      a_pend    <= '0;
      b_pend    <= '0;
      a_fresh   <= 1'b0;
      b_fresh   <= 1'b0;
      to_cnt    <= '0;
      pwm_q     <= 1'b0;
      fs_q      <= 1'b0;
      width_q   <= W_W'(NEUTRAL_US);
      src_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      psc       <= psc_nxt;
      us_cnt    <= us_nxt;
      a_pend    <= a_pend_nxt;
      b_pend    <= b_pend_nxt;
      a_fresh   <= a_fresh_nxt;
      b_fresh   <= b_fresh_nxt;
      to_cnt    <= to_cnt_nxt;
      pwm_q     <= pwm_nxt;
      fs_q      <= fs_nxt;
      width_q   <= width_nxt;
      src_q     <= src_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.frame_start = fs_q;
  assign bus.width_cur   = width_q;
  assign bus.active_src  = src_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_servo_pwm_sched.sv
// Frame-level reference check of servo_pwm_sched with scaled-down timing parameters.
module tb_servo_pwm_sched;

  localparam int CLK_PER_US = 2;
  localparam int FRAME_US   = 60;
  localparam int MIN_US     = 10;
  localparam int MAX_US     = 40;
  localparam int NEUTRAL_US = 25;
  localparam int TO_FRAMES  = 4;
  localparam int FC         = FRAME_US * CLK_PER_US;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servo_pwm_sched_if bus();

  servo_pwm_sched #(
    .CLK_PER_US     (CLK_PER_US),
    .FRAME_US       (FRAME_US),
    .MIN_US         (MIN_US),
    .MAX_US         (MAX_US),
    .NEUTRAL_US     (NEUTRAL_US),
    .TIMEOUT_FRAMES (TO_FRAMES)
  ) dut (
    .SYSCLK   (clk),
    .SYSRESET (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Frame-level model: what each frame should show, from the writes seen in the frame before
  int m_w, m_src, m_to, m_idle;
  bit m_a_seen, m_b_seen;
  int m_a_last, m_b_last;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampw(input int v);
    if (v < MIN_US) return MIN_US;
    if (v > MAX_US) return MAX_US;
    return v;
  endfunction

  function automatic int rand_width();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 4095));
      1:       return int'($urandom_range(0, MIN_US + 3));
      2:       return int'($urandom_range(MAX_US - 3, MAX_US + 10));
      default: return int'($urandom_range(MIN_US, MAX_US));
    endcase
  endfunction

  task automatic mdl_reset();
    m_w = NEUTRAL_US; m_src = 0; m_to = 0; m_idle = 0;
    m_a_seen = 0; m_b_seen = 0; m_a_last = 0; m_b_last = 0;
  endtask

  task automatic mdl_frame_start();
    if (m_a_seen) begin
      m_w = clampw(m_a_last); m_src = 1; m_to = 0; m_idle = 0;
    end else if (m_b_seen) begin
      m_w = clampw(m_b_last); m_src = 2; m_to = 0; m_idle = 0;
    end else begin
      if (m_idle < TO_FRAMES) m_idle++;
      if (m_idle == TO_FRAMES) begin
        m_w = NEUTRAL_US; m_src = 0; m_to = 1;
      end
    end
    m_a_seen = 0;
    m_b_seen = 0;
  endtask

  task automatic write_a(input int v);
    bus.a_wr = 1'b1; bus.a_width = 12'(v);
    m_a_seen = 1; m_a_last = v;
  endtask

  task automatic write_b(input int v);
    bus.b_wr = 1'b1; bus.b_width = 12'(v);
    m_b_seen = 1; m_b_last = v;
  endtask

  // Called at the negedge of an expected frame_start cycle
  task automatic frame_top();
    chk("frame_start", int'(bus.frame_start), 1);
    mdl_frame_start();
    chk("width_cur", int'(bus.width_cur), m_w);
    chk("active_src", int'(bus.active_src), m_src);
    chk("timeout", int'(bus.timeout), m_to);
  endtask

  // One full frame; a_at/b_at = cycle of a single write (-1 none), rmode bits = random A/B writes
  task automatic do_frame(input int a_at, input int a_val, input int b_at, input int b_val,
                          input int rmode);
    int high_cnt = 0;
    int bad_pwm  = 0;
    int bad_fs   = 0;
    frame_top();
    for (int c = 0; c < FC; c++) begin
      if (int'(bus.pwm_out) != ((c < m_w * CLK_PER_US) ? 1 : 0)) bad_pwm++;
      if (bus.pwm_out) high_cnt++;
      if (c > 0 && bus.frame_start) bad_fs++;
      bus.a_wr = 1'b0;
      bus.b_wr = 1'b0;
      if (c == a_at) write_a(a_val);
      if (c == b_at) write_b(b_val);
      if (rmode[0] && $urandom_range(0, 19) == 0) write_a(rand_width());
      if (rmode[1] && $urandom_range(0, 19) == 0) write_b(rand_width());
      @(negedge clk);
    end
    bus.a_wr = 1'b0;
    bus.b_wr = 1'b0;
    chk("pulse_len", high_cnt, m_w * CLK_PER_US);
    chk("pwm_shape", bad_pwm, 0);
    chk("extra_frame_start", bad_fs, 0);
  endtask

  // Cut a running pulse with disable (kind 0) or reset (kind 1), then restart
  task automatic interrupt(input int kind);
    int bad_idle = 0;
    frame_top();
    repeat (5) @(negedge clk);
    chk("pwm_pre_cut", int'(bus.pwm_out), 1);
    if (kind == 0) bus.enable = 1'b0;
    else           rst = 1'b1;
    @(negedge clk);
    chk("pwm_cut", int'(bus.pwm_out), 0);
    if (kind == 0) begin
      for (int i = 0; i < 5; i++) begin
        if (bus.pwm_out || bus.frame_start) bad_idle++;
        bus.b_wr = 1'b0;
        if (i == 2) write_b(17);
        @(negedge clk);
      end
      bus.b_wr = 1'b0;
      chk("idle_quiet", bad_idle, 0);
      bus.enable = 1'b1;
    end else begin
      mdl_reset();
      chk("rst_width", int'(bus.width_cur), NEUTRAL_US);
      chk("rst_src", int'(bus.active_src), 0);
      chk("rst_timeout", int'(bus.timeout), 0);
      rst = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int m;
    bus.enable = 1'b0; bus.a_wr = 1'b0; bus.a_width = '0;
    bus.b_wr = 1'b0; bus.b_width = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(bus.pwm_out), 0);
    chk("reset_fs", int'(bus.frame_start), 0);
    chk("reset_width", int'(bus.width_cur), NEUTRAL_US);
    chk("reset_src", int'(bus.active_src), 0);
    chk("reset_timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_pwm", int'(bus.pwm_out), 0);
    bus.enable = 1'b1;
    @(negedge clk);

    // No writes: neutral frames, deadman engages on the TO_FRAMES-th frame
    repeat (TO_FRAMES + 1) do_frame(-1, 0, -1, 0, 0);
    // Mid-frame A write only affects the following frame
    do_frame(30, 12, -1, 0, 0);
    do_frame(-1, 0, -1, 0, 0);
    // Simultaneous A/B: A wins, B is not carried over
    do_frame(50, 36, 50, 11, 0);
    do_frame(-1, 0, -1, 0, 0);
    // B below and above the legal range
    do_frame(-1, 0, 20, 3, 0);
    do_frame(-1, 0, 20, 4000, 0);
    do_frame(-1, 0, -1, 0, 0);
    // A once, then silence until the deadman, then B recovers
    do_frame(10, 34, -1, 0, 0);
    repeat (TO_FRAMES + 1) do_frame(-1, 0, -1, 0, 0);
    do_frame(-1, 0, 40, 13, 0);
    do_frame(-1, 0, -1, 0, 0);
    // Writes in the last cycle of a frame and in the frame_start cycle
    do_frame(FC - 1, 20, -1, 0, 0);
    do_frame(0, 30, -1, 0, 0);
    do_frame(-1, 0, -1, 0, 0);
    // Mid-pulse disable and mid-pulse reset
    interrupt(0);
    do_frame(-1, 0, -1, 0, 0);
    interrupt(1);
    do_frame(-1, 0, -1, 0, 0);
    // Randomized traffic
    repeat (150) begin
      m = int'($urandom_range(0, 5));
      do_frame(-1, 0, -1, 0, (m < 3) ? 0 : m - 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
